// File: rtl/user_entry.sv
// user_entry: synchronizes and debounces the slide switches and the submit button; one strobe per accepted press.
// Latency: raw press -> input_valid in DEBOUNCE_CYCLES+3 cycles; raw switch change -> switch_state in DEBOUNCE_CYCLES+2.
// Backpressure: none; input_valid is a single-cycle strobe that the consumer must sample when it is high.
module user_entry #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] switches,
  input  logic             submit_button,
  input  logic             enable,
  output logic [WIDTH-1:0] user_input,
  output logic             input_valid,
  output logic [WIDTH-1:0] switch_state,
  output logic             button_held
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_FIRE         = 2'd1,
    S_WAIT_RELEASE = 2'd2
  } state_t;

  // Two-flop synchronizers plus the previous-cycle synchronized copy used for restart detection.
  logic [WIDTH-1:0] r_sw_meta;
  logic [WIDTH-1:0] r_sw_s;
  logic [WIDTH-1:0] r_sw_prev;
  logic             r_btn_meta;
  logic             r_btn_s;
  logic             r_btn_prev;

  // Debounce state.
  logic [CNT_W-1:0] r_sw_cnt;
  logic [WIDTH-1:0] r_switch_state;
  logic [CNT_W-1:0] r_btn_cnt;
  logic             r_button_held;

  // Arming: a press that straddles reset must be released before it may fire.
  logic [CNT_W-1:0] r_arm_cnt;
  logic             r_armed;

  // Press FSM and its registered outputs.
  state_t           r_state;
  logic [WIDTH-1:0] r_user_input;
  logic             r_input_valid;

  // Combinational helpers, all on synchronized copies only.
  logic             w_btn_pressed;
  logic             w_btn_prev_pressed;
  logic             w_btn_released_quiet;

  assign w_btn_pressed        = ~r_btn_s;
  assign w_btn_prev_pressed   = ~r_btn_prev;
  // Both synchronizer stages must read released so the reset value of the
  // pipeline alone can never satisfy the arming count.
  assign w_btn_released_quiet = r_btn_s & r_btn_meta & ~r_button_held;

  // Synchronize raw inputs; button flops reset to released (1).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_meta  <= '0;
      r_sw_s     <= '0;
      r_sw_prev  <= '0;
      r_btn_meta <= 1'b1;
      r_btn_s    <= 1'b1;
      r_btn_prev <= 1'b1;
    end else begin
      r_sw_meta  <= switches;
      r_sw_s     <= r_sw_meta;
      r_sw_prev  <= r_sw_s;
      r_btn_meta <= submit_button;
      r_btn_s    <= r_btn_meta;
      r_btn_prev <= r_btn_s;
    end
  end

  // Switch debounce: accept a new value after DEBOUNCE_CYCLES identical samples.
  // A change while counting reloads 1 so the changed sample is the first of the run.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sw_cnt       <= '0;
      r_switch_state <= '0;
    end else if (r_sw_s == r_switch_state) begin
      r_sw_cnt <= '0;
    end else if (r_sw_s != r_sw_prev) begin
      r_sw_cnt <= LP_CNT_ONE;
    end else if (r_sw_cnt == LP_CNT_MAX) begin
      r_switch_state <= r_sw_s;
      r_sw_cnt       <= '0;
    end else begin
      r_sw_cnt <= r_sw_cnt + LP_CNT_ONE;
    end
  end

  // Button debounce: same scheme on the pressed level, independent counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_cnt     <= '0;
      r_button_held <= 1'b0;
    end else if (w_btn_pressed == r_button_held) begin
      r_btn_cnt <= '0;
    end else if (w_btn_pressed != w_btn_prev_pressed) begin
      r_btn_cnt <= LP_CNT_ONE;
    end else if (r_btn_cnt == LP_CNT_MAX) begin
      r_button_held <= w_btn_pressed;
      r_btn_cnt     <= '0;
    end else begin
      r_btn_cnt <= r_btn_cnt + LP_CNT_ONE;
    end
  end

  // Arm once the button has read quietly released for DEBOUNCE_CYCLES cycles; stays armed until reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
      r_armed   <= 1'b0;
    end else if (!w_btn_released_quiet) begin
      r_arm_cnt <= '0;
    end else if (!r_armed) begin
      if (r_arm_cnt == LP_CNT_MAX) begin
        r_armed <= 1'b1;
      end else begin
        r_arm_cnt <= r_arm_cnt + LP_CNT_ONE;
      end
    end
  end

  // Press FSM: the capture and strobe are registered on entry to FIRE, so input_valid
  // is high exactly while the FSM sits in FIRE and holds the pre-update switch_state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_user_input  <= '0;
      r_input_valid <= 1'b0;
    end else begin
      r_input_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_button_held && r_armed) begin
            if (enable) begin
              r_state       <= S_FIRE;
              r_user_input  <= r_switch_state;
              r_input_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT_RELEASE;
            end
          end
        end
        S_FIRE: begin
          r_state <= S_WAIT_RELEASE;
        end
        S_WAIT_RELEASE: begin
          if (!r_button_held) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign user_input   = r_user_input;
  assign input_valid  = r_input_valid;
  assign switch_state = r_switch_state;
  assign button_held  = r_button_held;

endmodule

// File: tb/tb_user_entry.sv
// tb_user_entry: directed scenarios plus randomized traffic against a run-length reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_user_entry;
  localparam int W = 8;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] switches = '0;
  logic         submit_button = 1'b1;
  logic         enable = 1'b1;
  logic [W-1:0] user_input;
  logic         input_valid;
  logic [W-1:0] switch_state;
  logic         button_held;

  int n_vec = 0;
  int n_err = 0;

  user_entry #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .switches      (switches),
    .submit_button (submit_button),
    .enable        (enable),
    .user_input    (user_input),
    .input_valid   (input_valid),
    .switch_state  (switch_state),
    .button_held   (button_held)
  );

  always #5 clock = ~clock;

  // Reference model: raw samples pass through a two-deep history; a level is
  // accepted once D consecutive synchronized samples agree; a press fires once
  // per debounced hold, only when armed and enabled.
  logic [W-1:0] q_sw[$];
  bit           q_bp[$];
  logic [W-1:0] m_ui, m_sw, last_sw, sw_b, s_sw;
  bit           m_valid, m_held, m_armed, m_consumed;
  bit           last_bp, s_bp, meta_bp, held_b, armed_b;
  int           run_sw, run_bp, run_arm;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_sw = {};
      q_sw.push_back('0);
      q_sw.push_back('0);
      q_bp = {};
      q_bp.push_back(1'b0);
      q_bp.push_back(1'b0);
      m_ui = '0; m_sw = '0; last_sw = '0;
      m_valid = 0; m_held = 0; m_armed = 0; m_consumed = 0; last_bp = 0;
      run_sw = 0; run_bp = 0; run_arm = 0;
    end else begin
      q_sw.push_back(switches);
      q_bp.push_back(!submit_button);
      s_sw    = q_sw[0];
      s_bp    = q_bp[0];
      meta_bp = q_bp[1];
      q_sw.delete(0);
      q_bp.delete(0);
      sw_b    = m_sw;
      held_b  = m_held;
      armed_b = m_armed;
      run_sw  = (s_sw == last_sw) ? run_sw + 1 : 1;
      last_sw = s_sw;
      if (s_sw != sw_b && run_sw >= D) m_sw = s_sw;
      run_bp  = (s_bp == last_bp) ? run_bp + 1 : 1;
      last_bp = s_bp;
      if (s_bp != held_b && run_bp >= D) m_held = s_bp;
      run_arm = (!s_bp && !meta_bp && !held_b) ? run_arm + 1 : 0;
      if (run_arm >= D) m_armed = 1;
      m_valid = held_b && armed_b && !m_consumed && enable;
      if (m_valid) m_ui = sw_b;
      if (held_b && armed_b) m_consumed = 1;
      else if (!held_b) m_consumed = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance n cycles, recording strobe count, first strobe cycle and the value it carried.
  task automatic observe(input int n, output int pulses, output int first, output logic [W-1:0] ui);
    pulses = 0;
    first  = 0;
    ui     = '0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (input_valid === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first = k;
          ui    = user_input;
        end
      end
    end
  endtask

  task automatic test_reset();
    int p, f;
    logic [W-1:0] u;
    reset_n = 1'b0; switches = 8'hA5; submit_button = 1'b0; enable = 1'b1;
    repeat (3) tick();
    n_vec++; if (user_input !== 8'h00) begin n_err++; $display("FAIL reset_user_input got %h want 00", user_input); end
    n_vec++; if (input_valid !== 1'b0) begin n_err++; $display("FAIL reset_input_valid got %b want 0", input_valid); end
    n_vec++; if (switch_state !== 8'h00) begin n_err++; $display("FAIL reset_switch_state got %h want 00", switch_state); end
    n_vec++; if (button_held !== 1'b0) begin n_err++; $display("FAIL reset_button_held got %b want 0", button_held); end
    reset_n = 1'b1;
    observe(30, p, f, u);
    n_vec++; if (p !== 0) begin n_err++; $display("FAIL reset_held_no_strobe got %0d pulses want 0", p); end
    n_vec++; if (switch_state !== 8'hA5) begin n_err++; $display("FAIL reset_switch_settle got %h want a5", switch_state); end
    n_vec++; if (button_held !== 1'b1) begin n_err++; $display("FAIL reset_button_debounced got %b want 1", button_held); end
    submit_button = 1'b1;
    observe(15, p, f, u);
    n_vec++; if (button_held !== 1'b0) begin n_err++; $display("FAIL reset_release got %b want 0", button_held); end
    submit_button = 1'b0;
    observe(15, p, f, u);
    n_vec++; if (p !== 1 || u !== 8'hA5) begin n_err++; $display("FAIL reset_repress got %0d pulses ui=%h want 1 pulse ui=a5", p, u); end
  endtask

  task automatic test_basic();
    int p, f;
    logic [W-1:0] u;
    submit_button = 1'b1; switches = 8'h3C;
    observe(15, p, f, u);
    submit_button = 1'b0;
    observe(20, p, f, u);
    n_vec++; if (switch_state !== 8'h3C) begin n_err++; $display("FAIL basic_switch_state got %h want 3c", switch_state); end
    n_vec++; if (p !== 1) begin n_err++; $display("FAIL basic_pulses got %0d want 1", p); end
    n_vec++; if (f !== D + 3) begin n_err++; $display("FAIL basic_latency got %0d want %0d", f, D + 3); end
    n_vec++; if (u !== 8'h3C) begin n_err++; $display("FAIL basic_capture got %h want 3c", u); end
    submit_button = 1'b1;
    observe(15, p, f, u);
    n_vec++; if (p !== 0 || user_input !== 8'h3C) begin n_err++; $display("FAIL basic_hold got %0d pulses ui=%h want 0 ui=3c", p, user_input); end
  endtask

  task automatic test_bounce();
    int p, f, tot;
    logic [W-1:0] u;
    submit_button = 1'b1; switches = 8'h96;
    observe(15, p, f, u);
    tot = 0;
    for (int i = 0; i < 6; i++) begin
      submit_button = (i % 2 == 0) ? 1'b0 : 1'b1;
      observe(2, p, f, u);
      tot += p;
    end
    n_vec++; if (tot !== 0) begin n_err++; $display("FAIL bounce_during got %0d pulses want 0", tot); end
    submit_button = 1'b0;
    observe(20, p, f, u);
    n_vec++; if (p !== 1 || f !== D + 3 || u !== 8'h96) begin n_err++; $display("FAIL bounce_final got %0d pulses at %0d ui=%h want 1 at %0d ui=96", p, f, u, D + 3); end
    submit_button = 1'b1;
    observe(15, p, f, u);
  endtask

  task automatic test_glitch();
    int p, f;
    logic [W-1:0] u;
    bit saw_ff;
    switches = 8'h00;
    observe(12, p, f, u);
    switches = 8'hFF;
    observe(3, p, f, u);
    switches = 8'h00;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_vec++; if (switch_state !== 8'h00) begin n_err++; $display("FAIL glitch_short cyc %0d got %h want 00", k, switch_state); end
    end
    switches = 8'hFF;
    observe(4, p, f, u);
    switches = 8'h00;
    saw_ff = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (switch_state === 8'hFF) saw_ff = 1;
    end
    n_vec++; if (!saw_ff || switch_state !== 8'h00) begin n_err++; $display("FAIL glitch_boundary saw_ff=%b final=%h want 1 and 00", saw_ff, switch_state); end
    submit_button = 1'b0;
    observe(20, p, f, u);
    n_vec++; if (p !== 1 || u !== 8'h00) begin n_err++; $display("FAIL glitch_submit got %0d pulses ui=%h want 1 ui=00", p, u); end
    submit_button = 1'b1;
    observe(15, p, f, u);
  endtask

  task automatic test_enable();
    int p, p2, f;
    logic [W-1:0] u;
    switches = 8'hC3;
    observe(12, p, f, u);
    enable = 1'b0; submit_button = 1'b0;
    observe(12, p, f, u);
    enable = 1'b1;
    observe(15, p2, f, u);
    n_vec++; if (p + p2 !== 0) begin n_err++; $display("FAIL enable_gated got %0d pulses want 0", p + p2); end
    submit_button = 1'b1;
    observe(15, p, f, u);
    submit_button = 1'b0;
    observe(20, p, f, u);
    n_vec++; if (p !== 1 || u !== 8'hC3) begin n_err++; $display("FAIL enable_repress got %0d pulses ui=%h want 1 ui=c3", p, u); end
    submit_button = 1'b1;
    observe(15, p, f, u);
  endtask

  task automatic test_reset_mid();
    int p, f;
    logic [W-1:0] u;
    switches = 8'h5A;
    observe(12, p, f, u);
    submit_button = 1'b0;
    observe(10, p, f, u);
    n_vec++; if (p !== 1) begin n_err++; $display("FAIL midreset_prefire got %0d pulses want 1", p); end
    reset_n = 1'b0;
    #1;
    n_vec++; if ({user_input, input_valid, switch_state, button_held} !== 18'h0) begin
      n_err++; $display("FAIL midreset_outputs got ui=%h v=%b ss=%h bh=%b want all 0", user_input, input_valid, switch_state, button_held);
    end
    tick();
    reset_n = 1'b1;
    observe(25, p, f, u);
    n_vec++; if (p !== 0) begin n_err++; $display("FAIL midreset_held got %0d pulses want 0", p); end
    submit_button = 1'b1;
    observe(15, p, f, u);
    submit_button = 1'b0;
    observe(20, p, f, u);
    n_vec++; if (p !== 1 || u !== 8'h5A) begin n_err++; $display("FAIL midreset_repress got %0d pulses ui=%h want 1 ui=5a", p, u); end
    submit_button = 1'b1;
    observe(15, p, f, u);
  endtask

  task automatic test_random();
    int btn_left, sw_left, pulses;
    btn_left = 0; sw_left = 0; pulses = 0;
    for (int c = 0; c < 4000; c++) begin
      if (btn_left == 0) begin
        submit_button = ~submit_button;
        btn_left = $urandom_range(1, 10);
      end
      if (sw_left == 0) begin
        switches = W'($urandom);
        sw_left = $urandom_range(1, 7);
      end
      btn_left--; sw_left--;
      enable  = ($urandom_range(0, 15) != 0);
      reset_n = !(c == 1500 || c == 3000);
      tick();
      if (input_valid === 1'b1) pulses++;
      n_vec++;
      if ({user_input, input_valid, switch_state, button_held} !== {m_ui, m_valid, m_sw, m_held}) begin
        n_err++;
        $display("FAIL random cyc %0d got ui=%h v=%b ss=%h bh=%b want ui=%h v=%b ss=%h bh=%b",
                 c, user_input, input_valid, switch_state, button_held, m_ui, m_valid, m_sw, m_held);
      end
    end
    reset_n = 1'b1;
    n_vec++; if (pulses == 0) begin n_err++; $display("FAIL random_activity got %0d strobes want >0", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_glitch();
    test_enable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
